// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and EX operand forwarding for a 5-stage
// in-order pipeline (IF, ID, EX, MEM, WB).
//
// A private shadow scoreboard mirrors the destination-register information of
// the instructions in EX, MEM and WB. From it the block derives:
//   - a load-use stall (hold PC and IF/ID, inject a bubble into ID/EX),
//   - a taken-branch flush (clear IF/ID and ID/EX),
//   - the EX operand forwarding selects.
//
// Handshake/flow semantics: there is no valid/ready pairing here. ID_Valid
// qualifies the ID-stage fields for the cycle it is sampled. The pipeline
// treats Stall_F/Stall_D as "hold this cycle" and Flush_D/Flush_E as "load a
// bubble on the coming edge". The shadow advances unconditionally every edge,
// exactly like the real pipeline registers it mirrors.
module pipe_hazard_ctrl #(
  parameter int AW     = 4,
  parameter int PC_REG = 15,
  parameter int CW     = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ID_Valid,
  input  logic [AW-1:0] ID_A1,
  input  logic [AW-1:0] ID_A2,
  input  logic          ID_Use1,
  input  logic          ID_Use2,
  input  logic          ID_RF_WE,
  input  logic [AW-1:0] ID_A3,
  input  logic          ID_WBSelect,
  input  logic          EX_BranchTaken,
  output logic          Stall_F,
  output logic          Stall_D,
  output logic          Flush_D,
  output logic          Flush_E,
  output logic [1:0]    FwdA_E,
  output logic [1:0]    FwdB_E,
  output logic [CW-1:0] StallCount,
  output logic [CW-1:0] FlushCount
);

  localparam logic [AW-1:0] PC_IDX = AW'(PC_REG);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // ---------------------------------------------------------------------------
  // Shadow scoreboard state. Only EX needs the Load flag (it is the sole
  // source of load-use hazards) and the source operands (for forwarding);
  // MEM and WB only need to say which register they are about to write.
  // ---------------------------------------------------------------------------
  logic          ex_v_q,    ex_v_d;
  logic          ex_we_q,   ex_we_d;
  logic [AW-1:0] ex_a3_q,   ex_a3_d;
  logic          ex_load_q, ex_load_d;
  logic [AW-1:0] ex_a1_q,   ex_a1_d;
  logic          ex_use1_q, ex_use1_d;
  logic [AW-1:0] ex_a2_q,   ex_a2_d;
  logic          ex_use2_q, ex_use2_d;

  logic          mem_v_q,   mem_v_d;
  logic          mem_we_q,  mem_we_d;
  logic [AW-1:0] mem_a3_q,  mem_a3_d;

  logic          wb_v_q,    wb_v_d;
  logic          wb_we_q,   wb_we_d;
  logic [AW-1:0] wb_a3_q,   wb_a3_d;

  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;

  // Raw hazard terms, before reset gating and priority.
  logic lu_hit;
  logic br_hit;

  // Per-operand "this stage writes the EX source register" terms.
  logic mem_wr_a1, mem_wr_a2;
  logic wb_wr_a1,  wb_wr_a2;

  // Gated control outputs.
  logic          stall_f, stall_d, flush_d, flush_e;
  logic [1:0]    fwd_a, fwd_b;

  // Detect the load-use hazard against the EX entry and the taken branch.
  always_comb begin
    lu_hit = 1'b0;
    br_hit = EX_BranchTaken;
    if (ex_v_q && ex_we_q && ex_load_q && ID_Valid && (ex_a3_q != PC_IDX)) begin
      lu_hit = (ID_Use1 && (ID_A1 == ex_a3_q)) ||
               (ID_Use2 && (ID_A2 == ex_a3_q));
    end
  end

  // Work out which later stage writes each EX source (PC is never forwarded).
  always_comb begin
    mem_wr_a1 = mem_v_q && mem_we_q && (mem_a3_q == ex_a1_q) && (ex_a1_q != PC_IDX);
    mem_wr_a2 = mem_v_q && mem_we_q && (mem_a3_q == ex_a2_q) && (ex_a2_q != PC_IDX);
    wb_wr_a1  = wb_v_q  && wb_we_q  && (wb_a3_q  == ex_a1_q) && (ex_a1_q != PC_IDX);
    wb_wr_a2  = wb_v_q  && wb_we_q  && (wb_a3_q  == ex_a2_q) && (ex_a2_q != PC_IDX);
  end

  // Resolve stall/flush priority (branch beats load-use) and gate by reset.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!RST) begin
      if (br_hit) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu_hit) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Choose EX operand sources; MEM is the younger result so it wins over WB.
  // A bubble in EX (V=0) never forwards.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!RST && ex_v_q) begin
      if (ex_use1_q && mem_wr_a1)     fwd_a = FWD_MEM;
      else if (ex_use1_q && wb_wr_a1) fwd_a = FWD_WB;
      if (ex_use2_q && mem_wr_a2)     fwd_b = FWD_MEM;
      else if (ex_use2_q && wb_wr_a2) fwd_b = FWD_WB;
    end
  end

  // Compute the next shadow contents: shift EX->MEM->WB and load EX from ID,
  // or with a bubble when ID/EX is being flushed. Reset empties every stage.
  always_comb begin
    wb_v_d   = mem_v_q;
    wb_we_d  = mem_we_q;
    wb_a3_d  = mem_a3_q;

    mem_v_d  = ex_v_q;
    mem_we_d = ex_we_q;
    mem_a3_d = ex_a3_q;

    ex_v_d    = ID_Valid;
    ex_we_d   = ID_RF_WE;
    ex_a3_d   = ID_A3;
    ex_load_d = ID_WBSelect;
    ex_a1_d   = ID_A1;
    ex_use1_d = ID_Use1;
    ex_a2_d   = ID_A2;
    ex_use2_d = ID_Use2;

    if (flush_e) begin
      ex_v_d    = 1'b0;
      ex_we_d   = 1'b0;
      ex_a3_d   = '0;
      ex_load_d = 1'b0;
      ex_a1_d   = '0;
      ex_use1_d = 1'b0;
      ex_a2_d   = '0;
      ex_use2_d = 1'b0;
    end

    if (RST) begin
      wb_v_d    = 1'b0;
      wb_we_d   = 1'b0;
      wb_a3_d   = '0;
      mem_v_d   = 1'b0;
      mem_we_d  = 1'b0;
      mem_a3_d  = '0;
      ex_v_d    = 1'b0;
      ex_we_d   = 1'b0;
      ex_a3_d   = '0;
      ex_load_d = 1'b0;
      ex_a1_d   = '0;
      ex_use1_d = 1'b0;
      ex_a2_d   = '0;
      ex_use2_d = 1'b0;
    end
  end

  // Count stall cycles (load-use not overridden by a branch) and flush cycles;
  // both wrap naturally at 2^CW.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (RST) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (lu_hit && !br_hit) stall_cnt_d = stall_cnt_q + CW'(1);
      if (br_hit)            flush_cnt_d = flush_cnt_q + CW'(1);
    end
  end

  // Register all shadow state and counters.
  always_ff @(posedge CLK) begin
    ex_v_q      <= ex_v_d;
    ex_we_q     <= ex_we_d;
    ex_a3_q     <= ex_a3_d;
    ex_load_q   <= ex_load_d;
    ex_a1_q     <= ex_a1_d;
    ex_use1_q   <= ex_use1_d;
    ex_a2_q     <= ex_a2_d;
    ex_use2_q   <= ex_use2_d;
    mem_v_q     <= mem_v_d;
    mem_we_q    <= mem_we_d;
    mem_a3_q    <= mem_a3_d;
    wb_v_q      <= wb_v_d;
    wb_we_q     <= wb_we_d;
    wb_a3_q     <= wb_a3_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign Stall_F    = stall_f;
  assign Stall_D    = stall_d;
  assign Flush_D    = flush_d;
  assign Flush_E    = flush_e;
  assign FwdA_E     = fwd_a;
  assign FwdB_E     = fwd_b;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl. Inputs change 1ns
// after each rising edge; the combinational outputs are checked 1ns later,
// well away from the next edge. Expected values are hand-derived from the
// pipeline timeline written next to each step.
module tb_pipe_hazard_ctrl;

  logic        CLK;
  logic        RST;
  logic        ID_Valid;
  logic [3:0]  ID_A1, ID_A2, ID_A3;
  logic        ID_Use1, ID_Use2, ID_RF_WE, ID_WBSelect;
  logic        EX_BranchTaken;
  logic        Stall_F, Stall_D, Flush_D, Flush_E;
  logic [1:0]  FwdA_E, FwdB_E;
  logic [31:0] StallCount, FlushCount;

  int passed = 0;
  int total  = 0;

  pipe_hazard_ctrl #(.AW(4), .PC_REG(15), .CW(32)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ID_Valid       (ID_Valid),
    .ID_A1          (ID_A1),
    .ID_A2          (ID_A2),
    .ID_Use1        (ID_Use1),
    .ID_Use2        (ID_Use2),
    .ID_RF_WE       (ID_RF_WE),
    .ID_A3          (ID_A3),
    .ID_WBSelect    (ID_WBSelect),
    .EX_BranchTaken (EX_BranchTaken),
    .Stall_F        (Stall_F),
    .Stall_D        (Stall_D),
    .Flush_D        (Flush_D),
    .Flush_E        (Flush_E),
    .FwdA_E         (FwdA_E),
    .FwdB_E         (FwdB_E),
    .StallCount     (StallCount),
    .FlushCount     (FlushCount)
  );

  // Clock and reset start values
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive the ID-stage instruction fields.
  task automatic set_id(input logic v, input logic [3:0] a1, input logic u1,
                        input logic [3:0] a2, input logic u2, input logic we,
                        input logic [3:0] a3, input logic ld);
    ID_Valid    = v;
    ID_A1       = a1;
    ID_Use1     = u1;
    ID_A2       = a2;
    ID_Use2     = u2;
    ID_RF_WE    = we;
    ID_A3       = a3;
    ID_WBSelect = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    RST = 1'b1;
    EX_BranchTaken = 1'b0;
    idle();
    step();
    step();
    RST = 1'b0;
    #1;
    // Reset state
    chk("rst_stall_f", Stall_F, 0);
    chk("rst_flush_e", Flush_E, 0);
    chk("rst_fwda", FwdA_E, 0);
    chk("rst_stallcnt", StallCount, 0);
    chk("rst_flushcnt", FlushCount, 0);

    // ADD r1 then SUB r6,r1,r2: SUB in EX sees ADD in MEM -> FwdA=01
    step(); set_id(1, 0, 0, 0, 0, 1, 1, 0); #1;
    step(); set_id(1, 1, 1, 2, 1, 1, 6, 0); #1;
    chk("alu_nostall", Stall_F, 0);
    step(); idle(); #1;
    chk("alu_fwda_mem", FwdA_E, 2'b01);
    chk("alu_fwdb_rf", FwdB_E, 2'b00);
    step(); #1;
    chk("bubble_nofwd", FwdA_E, 2'b00);
    step(); step();

    // LDR r2 then ADD r3,r2,r4: one stall cycle, then FwdA=10 from WB
    step(); set_id(1, 0, 0, 0, 0, 1, 2, 1); #1;
    chk("ldr_noself", Stall_F, 0);
    step(); set_id(1, 2, 1, 4, 1, 1, 3, 0); #1;
    chk("lu_stall_f", Stall_F, 1);
    chk("lu_stall_d", Stall_D, 1);
    chk("lu_flush_e", Flush_E, 1);
    chk("lu_flush_d", Flush_D, 0);
    chk("lu_cnt_before", StallCount, 0);
    step(); #1;  // ADD held in ID, bubble in EX, LDR in MEM
    chk("lu_released", Stall_F, 0);
    chk("lu_released_fe", Flush_E, 0);
    chk("lu_cnt_after", StallCount, 1);
    step(); idle(); #1;  // ADD in EX, LDR in WB
    chk("lu_fwda_wb", FwdA_E, 2'b10);
    chk("lu_fwdb_rf", FwdB_E, 2'b00);
    step(); step();

    // r5 written by instructions now in MEM and WB; reader in EX -> FwdB=01
    step(); set_id(1, 0, 0, 0, 0, 1, 5, 0);
    step(); set_id(1, 0, 0, 0, 0, 1, 5, 0);
    step(); set_id(1, 6, 1, 5, 1, 1, 7, 0); #1;
    chk("r5_nostall", Stall_F, 0);
    step(); idle(); #1;
    chk("r5_fwdb_mem", FwdB_E, 2'b01);
    chk("r5_fwda_rf", FwdA_E, 2'b00);
    step(); step();

    // Taken branch with a load-use present: branch wins
    step(); set_id(1, 0, 0, 0, 0, 1, 8, 1);
    step(); set_id(1, 8, 1, 0, 0, 1, 9, 0); EX_BranchTaken = 1'b1; #1;
    chk("br_flush_d", Flush_D, 1);
    chk("br_flush_e", Flush_E, 1);
    chk("br_stall_f", Stall_F, 0);
    chk("br_stall_d", Stall_D, 0);
    step(); EX_BranchTaken = 1'b0; idle(); #1;
    chk("br_flushcnt", FlushCount, 1);
    chk("br_stallcnt", StallCount, 1);
    chk("br_ex_bubble", FwdA_E, 2'b00);
    chk("br_no_flush", Flush_D, 0);
    step(); step();

    // LDR r15 then reader of r15: PC register never stalls or forwards
    step(); set_id(1, 0, 0, 0, 0, 1, 15, 1);
    step(); set_id(1, 15, 1, 15, 1, 1, 4, 0); #1;
    chk("pc_nostall", Stall_F, 0);
    chk("pc_noflush", Flush_E, 0);
    step(); idle(); #1;
    chk("pc_fwda", FwdA_E, 2'b00);
    chk("pc_fwdb", FwdB_E, 2'b00);
    step(); step();

    // ID_Valid=0 never produces load-use
    step(); set_id(1, 0, 0, 0, 0, 1, 10, 1);
    step(); set_id(0, 10, 1, 10, 1, 1, 4, 0); #1;
    chk("novalid_nostall", Stall_F, 0);
    step(); idle(); step(); step();

    // RST pulsed with a load in EX and a dependent reader in ID
    step(); set_id(1, 0, 0, 0, 0, 1, 9, 1);
    step(); RST = 1'b1; set_id(1, 9, 1, 0, 0, 1, 4, 0); #1;
    chk("inrst_stall_f", Stall_F, 0);
    chk("inrst_flush_e", Flush_E, 0);
    step(); RST = 1'b0; #1;
    chk("postrst_nostall", Stall_F, 0);
    chk("postrst_stallcnt", StallCount, 0);
    chk("postrst_flushcnt", FlushCount, 0);
    step(); idle(); #1;
    chk("postrst_fwda", FwdA_E, 2'b00);
    step(); step();

    // Load-use through operand B
    step(); set_id(1, 0, 0, 0, 0, 1, 11, 1);
    step(); set_id(1, 0, 0, 11, 1, 1, 12, 0); #1;
    chk("lub_stall", Stall_F, 1);
    step(); #1;
    chk("lub_cnt", StallCount, 1);
    chk("lub_released", Stall_F, 0);
    step(); idle(); #1;
    chk("lub_fwdb_wb", FwdB_E, 2'b10);
    chk("lub_fwda_rf", FwdA_E, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It tracks the destination register of every in-flight instruction in EX, MEM and WB using its own shadow scoreboard. From that it generates PC/IF-ID stall, IF-ID/ID-EX flush and EX operand-forward selects. It sits beside the ID/EX pipeline register and drives that register's clear, plus the IF/ID enable and clear.

## Interface
Parameters:
- AW, 4, register address width
- PC_REG, 15, register index never forwarded or hazard-checked (PC)
- CW, 32, width of performance counters

Ports:
- CLK  in  1  clock, all state updates on posedge
- RST  in  1  synchronous, active-high reset
- ID_Valid  in  1  ID holds a real instruction
- ID_A1, ID_A2  in  AW  source registers read in ID
- ID_Use1, ID_Use2  in  1  source actually read
- ID_RF_WE  in  1  instruction in ID writes the register file
- ID_A3  in  AW  its destination
- ID_WBSelect  in  1  1 = write-back from data memory (load)
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle
- Stall_F  out  1  hold PC
- Stall_D  out  1  hold IF/ID
- Flush_D  out  1  clear IF/ID on next edge
- Flush_E  out  1  load bubble into ID/EX on next edge
- FwdA_E, FwdB_E  out  2  EX operand select: 00 = register file, 01 = MEM ALU result, 10 = WB result
- StallCount, FlushCount  out  CW  performance counters

## Operation
Each shadow stage holds {V, WE, A3, Load}. The EX stage also holds A1/Use1 and A2/Use2.

- Valid write: an entry "writes r" when V & WE & A3==r & r!=PC_REG.
- Load-use hazard (LU): EX entry V & WE & Load, and (ID_Use1 & ID_A1==EX.A3) or (ID_Use2 & ID_A2==EX.A3), with ID_Valid=1 and EX.A3!=PC_REG.
- Branch flush (BR): EX_BranchTaken=1.
- Output priority:
  - BR: Flush_D=1, Flush_E=1, Stall_F=0, Stall_D=0.
  - LU only: Stall_F=1, Stall_D=1, Flush_E=1, Flush_D=0.
  - Neither: all four 0.
- Forwarding for operand A:
  - 01 if EX.Use1 and MEM writes EX.A1.
  - Else 10 if EX.Use1 and WB writes EX.A1.
  - Else 00.
  - MEM has priority over WB. Operand B is identical using A2/Use2.
- All outputs are combinational from shadow state plus ID/EX inputs. They are forced to 0 (counters excepted) while RST=1.
- Shadow advance each posedge:
  - WB <= MEM; MEM <= EX.
  - EX <= invalid entry if Flush_E, else {ID_Valid, ID_RF_WE, ID_A3, ID_WBSelect, A1/A2/Use}.
  - The instruction currently in EX always advances; a taken branch does not cancel itself.
- Counters:
  - StallCount +1 per cycle with LU and not BR.
  - FlushCount +1 per cycle with BR.
  - Both wrap modulo 2^CW.

## Timing
- Reset: all shadow V=0, counters 0. First cycle after RST deasserts: Stall/Flush=0, Fwd=00.
- RST asserted mid-operation clears the scoreboard on that edge. No forwarding or stall refers to pre-reset instructions.
- Load-use costs exactly 1 stall cycle:
  - Cycle n: LU detected; bubble enters EX.
  - Cycle n+1: the load is in MEM and the dependent instruction is in ID. LU is now 0 and the instruction proceeds.
  - Cycle n+2: the dependent instruction is in EX and receives Fwd=10 from WB.
- Branch penalty is 2 cycles. Both younger instructions are cleared on the edge after BR.
- LU and BR in the same cycle: BR wins. StallCount does not increment; FlushCount does.
- A bubble (V=0) never produces forwarding or hazards.
- ID_Valid=0 never produces LU.
- Writes or reads of PC_REG never stall or forward.

## Test plan
- ADD r1 in EX, SUB reading r1 next: FwdA_E=01 at the SUB's EX cycle; Stall=0.
- LDR r2, then ADD r3,r2,r4: one cycle with Stall_F=Stall_D=Flush_E=1 and StallCount=1, then the ADD in EX with FwdA_E=10.
- r5 written by both MEM and WB entries, read in EX: FwdB_E=01 (MEM priority).
- EX_BranchTaken=1 while LU is present: Flush_D=Flush_E=1, Stall_F=0, FlushCount +1, StallCount unchanged.
- LDR r15 followed by a reader of r15: no stall, Fwd=00.
- RST pulsed with a load in EX: next cycle a dependent read produces no stall and Fwd=00; counters read 0.
